// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe referee and its win detector.
//   - cell codes (VACIA, P1, P2)
//   - line-to-cell table: 8 lines of 3 cells each, cells numbered 0..8
//   - referee state encoding
//   - helpers that slice a cell out of an 18-bit board and test a line
package gato_pkg;

  localparam logic [1:0] VACIA = 2'b00;
  localparam logic [1:0] P1    = 2'b11;
  localparam logic [1:0] P2    = 2'b01;

  // Cell numbers are 0-based here: cell k of the board lives at bits [2k+1:2k].
  localparam logic [3:0] LINEAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TURNO_P1 = 3'd1,
    TURNO_P2 = 3'd2,
    APLICA   = 3'd3,
    JUZGA    = 3'd4,
    FIN      = 3'd5
  } estado_t;

  function automatic logic [1:0] celda(input logic [17:0] tab, input int k);
    return tab[2*k +: 2];
  endfunction

  function automatic logic linea_llena(input logic [17:0] tab, input int l,
                                       input logic [1:0] codigo);
    return (celda(tab, int'(LINEAS[l][0])) == codigo) &&
           (celda(tab, int'(LINEAS[l][1])) == codigo) &&
           (celda(tab, int'(LINEAS[l][2])) == codigo);
  endfunction

endpackage

// File: rtl/arbitro_gato_if.sv
// Link between the cell selector and the referee.
//   p1_mm / p2_mm : selector commit flags (rising edge = move committed)
//   tablero       : selector's 18-bit cell codes
//   turno_p1/_p2  : referee grants the move to a player
// master = selector side, slave = referee side.
interface arbitro_gato_if;
  logic        p1_mm;
  logic        p2_mm;
  logic [17:0] tablero;
  logic        turno_p1;
  logic        turno_p2;

  modport master (output p1_mm, p2_mm, tablero, input turno_p1, turno_p2);
  modport slave  (input p1_mm, p2_mm, tablero, output turno_p1, turno_p2);
endinterface

// File: rtl/gato_detector_ganador.sv
// Combinational win detector over an 18-bit board.
//   i_tablero  : board, 2 bits per cell
//   o_gana_p1  : some line is all P1
//   o_gana_p2  : some line is all P2
//   o_linea    : lowest-index matching line (0 when none)
module gato_detector_ganador
  import gato_pkg::*;
(
  input  logic [17:0] i_tablero,
  output logic        o_gana_p1,
  output logic        o_gana_p2,
  output logic [2:0]  o_linea
);

  // Scan high-to-low so the lowest matching line is the one left in o_linea.
  always_comb begin
    o_gana_p1 = 1'b0;
    o_gana_p2 = 1'b0;
    o_linea   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (linea_llena(i_tablero, i, P1)) begin
        o_gana_p1 = 1'b1;
        o_linea   = 3'(i);
      end else if (linea_llena(i_tablero, i, P2)) begin
        o_gana_p2 = 1'b1;
        o_linea   = 3'(i);
      end else begin
        o_linea   = o_linea;
      end
    end
  end

endmodule

// File: rtl/arbitro_gato.sv
// Tic-tac-toe referee. Grants turns to the selector, validates each committed
// move against an internal authoritative board copy and detects win/draw.
//   clk, rst_n        : clock, async active-low reset
//   nuevo_juego       : start/restart pulse, overrides everything
//   sel (slave)       : p1_mm/p2_mm/tablero in, turno_p1/turno_p2 out
//   gana_p1/gana_p2   : win flags, held until nuevo_juego; linea_ganadora
//   empate            : draw flag, held until nuevo_juego
//   movimientos       : accepted moves 0..9
//   jugada_invalida   : 1-cycle pulse on rejected move
//   turno_perdido     : 1-cycle pulse on turn timeout (0 unless TURN_TIMEOUT_EN)
// Optional feature macro: TURN_TIMEOUT_EN.
module arbitro_gato
  import gato_pkg::*;
#(
  parameter int PRIMER_JUGADOR = 0,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           nuevo_juego,
  arbitro_gato_if.slave  sel,
  output logic           gana_p1,
  output logic           gana_p2,
  output logic           empate,
  output logic [2:0]     linea_ganadora,
  output logic [3:0]     movimientos,
  output logic           jugada_invalida,
  output logic           turno_perdido
);

  localparam estado_t PRIMERO = (PRIMER_JUGADOR == 0) ? TURNO_P1 : TURNO_P2;

  estado_t     r_estado, w_siguiente;
  logic [17:0] r_copia, r_base;
  logic        r_p1_q, r_p2_q, r_mueve_p2;
  logic [3:0]  r_movs;
  logic        r_gana_p1, r_gana_p2, r_empate, r_invalida, r_perdido;
  logic        r_turno_p1, r_turno_p2;
  logic [2:0]  r_linea;

  logic        w_ev1, w_ev2, w_ev_actual, w_expira, w_legal;
  logic [3:0]  w_ndiff, w_idx;
  logic [1:0]  w_codigo;
  logic        w_g1, w_g2;
  logic [2:0]  w_linea;

  assign w_ev1       = sel.p1_mm & ~r_p1_q;
  assign w_ev2       = sel.p2_mm & ~r_p2_q;
  assign w_ev_actual = ((r_estado == TURNO_P1) & w_ev1) | ((r_estado == TURNO_P2) & w_ev2);
  assign w_codigo    = r_mueve_p2 ? P2 : P1;

  gato_detector_ganador u_detector (
    .i_tablero (r_copia),
    .o_gana_p1 (w_g1),
    .o_gana_p2 (w_g2),
    .o_linea   (w_linea)
  );

  // Locate the cells that changed since the last snapshot and judge legality.
  always_comb begin
    w_ndiff = 4'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (celda(sel.tablero, k) != celda(r_base, k)) begin
        w_ndiff = w_ndiff + 4'd1;
        w_idx   = 4'(k);
      end else begin
        w_idx   = w_idx;
      end
    end
    w_legal = (w_ndiff == 4'd1) &&
              (celda(sel.tablero, int'(w_idx)) == w_codigo) &&
              (celda(r_copia, int'(w_idx)) == VACIA);
  end

`ifdef TURN_TIMEOUT_EN
  logic [25:0] r_cnt;

  assign w_expira = ((r_estado == TURNO_P1) || (r_estado == TURNO_P2)) &&
                    (r_cnt == 26'(TIMEOUT_CICLOS - 1));

  // Turn timer: restarts on every entry into a turn, runs while in a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 26'd0;
    end else if (nuevo_juego ||
                 (((w_siguiente == TURNO_P1) || (w_siguiente == TURNO_P2)) &&
                  (w_siguiente != r_estado))) begin
      r_cnt <= 26'd0;
    end else if ((r_estado == TURNO_P1) || (r_estado == TURNO_P2)) begin
      r_cnt <= r_cnt + 26'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_expira = 1'b0;
`endif

  // Next-state logic; nuevo_juego overrides whatever the state would do.
  always_comb begin
    w_siguiente = r_estado;
    if (nuevo_juego) begin
      w_siguiente = PRIMERO;
    end else begin
      case (r_estado)
        IDLE:     w_siguiente = IDLE;
        TURNO_P1: w_siguiente = w_ev1 ? APLICA : (w_expira ? TURNO_P2 : TURNO_P1);
        TURNO_P2: w_siguiente = w_ev2 ? APLICA : (w_expira ? TURNO_P1 : TURNO_P2);
        APLICA:   w_siguiente = w_legal ? JUZGA : (r_mueve_p2 ? TURNO_P2 : TURNO_P1);
        JUZGA: begin
          if (w_g1 || w_g2 || (r_movs == 4'd9)) begin
            w_siguiente = FIN;
          end else begin
            w_siguiente = r_mueve_p2 ? TURNO_P1 : TURNO_P2;
          end
        end
        FIN:      w_siguiente = FIN;
        default:  w_siguiente = IDLE;
      endcase
    end
  end

  // State register and move-flag edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= IDLE;
      r_p1_q     <= 1'b0;
      r_p2_q     <= 1'b0;
      r_mueve_p2 <= 1'b0;
      r_turno_p1 <= 1'b0;
      r_turno_p2 <= 1'b0;
    end else begin
      r_estado   <= w_siguiente;
      r_p1_q     <= sel.p1_mm;
      r_p2_q     <= sel.p2_mm;
      r_mueve_p2 <= (r_estado == TURNO_P1) ? 1'b0 :
                    (r_estado == TURNO_P2) ? 1'b1 : r_mueve_p2;
      r_turno_p1 <= (w_siguiente == TURNO_P1);
      r_turno_p2 <= (w_siguiente == TURNO_P2);
    end
  end

  // Board copy, snapshot, move count and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_copia    <= 18'd0;
      r_base     <= 18'd0;
      r_movs     <= 4'd0;
      r_gana_p1  <= 1'b0;
      r_gana_p2  <= 1'b0;
      r_empate   <= 1'b0;
      r_linea    <= 3'd0;
      r_invalida <= 1'b0;
      r_perdido  <= 1'b0;
    end else if (nuevo_juego) begin
      r_copia    <= 18'd0;
      r_base     <= sel.tablero;
      r_movs     <= 4'd0;
      r_gana_p1  <= 1'b0;
      r_gana_p2  <= 1'b0;
      r_empate   <= 1'b0;
      r_linea    <= 3'd0;
      r_invalida <= 1'b0;
      r_perdido  <= 1'b0;
    end else begin
      r_invalida <= 1'b0;
      r_perdido  <= w_expira & ~w_ev_actual;
      case (r_estado)
        APLICA: begin
          r_base <= sel.tablero;
          if (w_legal) begin
            r_copia[{w_idx, 1'b0} +: 2] <= w_codigo;
            r_movs <= (r_movs == 4'd9) ? 4'd9 : r_movs + 4'd1;
          end else begin
            r_invalida <= 1'b1;
          end
        end
        JUZGA: begin
          if (w_g1 || w_g2) begin
            r_gana_p1 <= w_g1;
            r_gana_p2 <= w_g2;
            r_linea   <= w_linea;
          end else if (r_movs == 4'd9) begin
            r_empate  <= 1'b1;
          end else begin
            r_empate  <= 1'b0;
          end
        end
        default: r_base <= r_base;
      endcase
    end
  end

  assign sel.turno_p1    = r_turno_p1;
  assign sel.turno_p2    = r_turno_p2;
  assign gana_p1         = r_gana_p1;
  assign gana_p2         = r_gana_p2;
  assign empate          = r_empate;
  assign linea_ganadora  = r_linea;
  assign movimientos     = r_movs;
  assign jugada_invalida = r_invalida;
  assign turno_perdido   = r_perdido;

endmodule
